pwm_duty_ctrl: RTL and testbench
================================

// Module: pwm_duty_ctrl
// PURPOSE
//  Duty-cycle controller for the PWM datapath. Conditions the three user switches: SW0 enable, SW1 increase, SW2 decrease.
//  Holds a saturating duty register (percent) and drives the PWM generator's duty/enable inputs.
//  Emits registered BCD digits for the HEX2/HEX1/HEX0 seven-segment decoders. Sits between SW[2:0] and the PWM core in top.
// PARAMETERS
//  DEB_CYCLES   16   consecutive stable cycles required before a debounced level changes (>=1)
//  STEP         10   duty increment/decrement per accepted press, percent (1..100)
//  MAX_DUTY     100  upper saturation limit, percent (<=100)
//  RESET_DUTY   50   duty register value after reset (<=MAX_DUTY)
//  REPEAT_CYCLES 1000 hold interval between auto-repeat steps (used only with PWM_AUTO_REPEAT_EN)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  asynchronous, active-high reset
//  en_sw      in   1  raw SW0 level; 1 = PWM on
//  inc_sw     in   1  raw SW1 level; rising edge = duty += STEP
//  dec_sw     in   1  raw SW2 level; rising edge = duty -= STEP
//  pwm_en     out  1  debounced enable to PWM core
//  duty       out  7  duty to PWM core, 0..MAX_DUTY; forced 0 while pwm_en=0
//  duty_upd   out  1  one-cycle pulse when the duty output value changes
//  bcd_hund   out  4  hundreds digit of duty (0/1)
//  bcd_tens   out  4  tens digit of duty (0..9)
//  bcd_ones   out  4  units digit of duty (0..9)
// BEHAVIOUR
//  Reset: pwm_en=0, duty=0, duty_upd=0, all bcd_*=0; internal duty_reg=RESET_DUTY; sync/debounce state=0; counters=0.
//  Per input: 2-FF synchronizer, then debouncer. Counter increments while sync output != debounced level.
//    Counter clears when they match. When the count reaches DEB_CYCLES, the level flips and the counter clears.
//  Timing: raw change first sampled at edge N -> debounced level flips at edge N+1+DEB_CYCLES.
//    Pulses shorter than DEB_CYCLES cycles are discarded.
//  Press event = debounced rising edge of inc/dec, one cycle wide. duty_reg updates at edge N+2+DEB_CYCLES.
//  Increment: duty_reg = min(duty_reg+STEP, MAX_DUTY). Decrement: max(duty_reg-STEP, 0).
//    Compute in 8 bits, no wrap-around.
//  inc and dec events in the same cycle: no change.
//  Events while pwm_en=0 are ignored; duty_reg is retained across disable/enable.
//  duty = pwm_en ? duty_reg : 0, registered, same edge as duty_reg/pwm_en update.
//  duty_upd is high in the cycle after the duty output changes; it is not asserted at saturation (no change).
//  BCD: registered from duty, one cycle after duty. Values 0..100 only; displays 000 while disabled.
//  Reset asserted mid-debounce or mid-repeat: all counters abort immediately; no event is generated after release.
// CONFIGURATION
//  PWM_AUTO_REPEAT_EN defined:
//    - A debounced inc/dec held high continuously generates an additional event every REPEAT_CYCLES cycles after the initial event.
//    - Saturating rules apply to every event.
//    - Releasing the switch, or both inc and dec high together, clears the repeat counter.
//  PWM_AUTO_REPEAT_EN undefined: one event per rising edge only. No repeat counter is synthesized; REPEAT_CYCLES is unused.
// STRUCTURE
//  Package pwm_ctrl_pkg: DUTY_W=7, PCT_MAX=100, BCD_W=4 constants; function min/max-saturate helper; bcd3_t digit struct/typedef.
//  Sub-module sw_debounce: synchronizer + debouncer + rise pulse, param DEB_CYCLES.
//    Instantiated 3x (en/inc/dec).
//  Top of block: event arbitration, duty register, optional repeat counter, BCD register.
// TESTING (DEB_CYCLES=4 in bench, defaults otherwise)
//  1 Reset then en_sw=1 held 10 cycles -> pwm_en=1, duty=50, bcd=0/5/0, one duty_upd pulse.
//  2 inc_sw pulse 2 cycles -> duty stays 50, no duty_upd.
//    inc_sw held 8 cycles -> duty=60 exactly at N+6 edge, bcd 0/6/0 one cycle later.
//  3 Five inc presses from 60 -> 70,80,90,100,100; fifth gives no duty_upd. Dec from 0 stays 0.
//  4 inc_sw and dec_sw raised same cycle, held 8 -> duty unchanged.
//    en_sw=0 -> duty=0, bcd 000. Press inc, then re-enable -> duty restores 60, not 70.
//  5 Assert rst while inc debounce count=3 -> outputs reset, no step after release.
//  6 PWM_AUTO_REPEAT_EN, REPEAT_CYCLES=20: hold inc 70 cycles from 50.
//    -> duty 60, 70, 80, 90 at 20-cycle spacing. Release stops stepping.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : pwm_ctrl_pkg                                                   |
// | Purpose : Shared widths, the BCD digit record and the arithmetic helpers |
// |           used by the PWM duty-cycle controller.                         |
// | Contents: DUTY_W, PCT_MAX, BCD_W constants; bcd3_t; sat_step(); to_bcd() |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package pwm_ctrl_pkg;

    localparam int DUTY_W  = 7;
    localparam int PCT_MAX = 100;
    localparam int BCD_W   = 4;

    typedef struct packed {
        logic [BCD_W-1:0] hund;
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd3_t;

    // One saturating step. The extra bit keeps val+step (at most 200) from
    // wrapping before it is clamped to lim.
    function automatic logic [DUTY_W-1:0] sat_step(
        input logic [DUTY_W-1:0] val,
        input logic              up,
        input logic [DUTY_W:0]   step,
        input logic [DUTY_W:0]   lim
    );
        logic [DUTY_W:0] wide;
        wide = {1'b0, val};
        if (up) begin
            wide = wide + step;
            if (wide > lim) begin
                wide = lim;
            end
        end else if (wide < step) begin
            wide = '0;
        end else begin
            wide = wide - step;
        end
        return wide[DUTY_W-1:0];
    endfunction

    // Three-digit split of a percentage in the range 0..100.
    function automatic bcd3_t to_bcd(input logic [DUTY_W-1:0] val);
        bcd3_t             b;
        logic [DUTY_W-1:0] rem;
        if (val >= DUTY_W'(PCT_MAX)) begin
            b.hund = BCD_W'(1);
            rem    = val - DUTY_W'(PCT_MAX);
        end else begin
            b.hund = '0;
            rem    = val;
        end
        b.tens = BCD_W'(rem / DUTY_W'(10));
        b.ones = BCD_W'(rem % DUTY_W'(10));
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sw_debounce                                                    |
// | Purpose : Two-flop synchronizer, counting debouncer and rising-edge      |
// |           pulse for one mechanical switch.                               |
// | Ports   : clk, rst (async, active high), raw (switch level),             |
// |           level (debounced), level_nxt (value level takes at the next    |
// |           edge), rise (one-cycle pulse after level goes 0->1)            |
// | Params  : DEB_CYCLES - stable cycles needed before level changes (>=1)   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module sw_debounce
    import pwm_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic level_nxt,
    output logic rise
);

    localparam int                 c_cnt_w    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_d;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_level_nxt;

    // The counter runs only while the synchronized input disagrees with the
    // debounced level; any agreement, or the flip itself, restarts it.
    always_comb begin
        w_level_nxt = r_level;
        w_cnt_nxt   = '0;
        if (r_sync2 != r_level) begin
            if (r_cnt == c_cnt_last) begin
                w_level_nxt = r_sync2;
            end else begin
                w_cnt_nxt = r_cnt + c_cnt_w'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= raw;
            r_sync2   <= r_sync1;
            r_level   <= w_level_nxt;
            r_level_d <= r_level;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign level     = r_level;
    assign level_nxt = w_level_nxt;
    assign rise      = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/pwm_duty_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pwm_duty_ctrl                                                  |
// | Purpose : Conditions SW0 (enable), SW1 (increase), SW2 (decrease), keeps |
// |           a saturating duty percentage and drives the PWM core and the   |
// |           HEX2..HEX0 BCD digits.                                         |
// | Ports   : clk, rst (async, active high), en_sw, inc_sw, dec_sw (raw);    |
// |           pwm_en, duty[6:0], duty_upd, bcd_hund, bcd_tens, bcd_ones      |
// | Macro   : PWM_AUTO_REPEAT_EN - a held inc/dec switch re-steps every      |
// |           REPEAT_CYCLES cycles; undefined means one step per press.      |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES    = 16,
    parameter int STEP          = 10,
    parameter int MAX_DUTY      = 100,
    parameter int RESET_DUTY    = 50,
    parameter int REPEAT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_sw,
    input  logic              inc_sw,
    input  logic              dec_sw,
    output logic              pwm_en,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic [BCD_W-1:0]  bcd_hund,
    output logic [BCD_W-1:0]  bcd_tens,
    output logic [BCD_W-1:0]  bcd_ones
);

    localparam logic [DUTY_W:0]   c_step       = (DUTY_W+1)'(STEP);
    localparam logic [DUTY_W:0]   c_max        = (DUTY_W+1)'(MAX_DUTY);
    localparam logic [DUTY_W-1:0] c_reset_duty = DUTY_W'(RESET_DUTY);

    logic w_en_lvl, w_en_nxt, w_en_rise;
    logic w_inc_lvl, w_inc_nxt, w_inc_rise;
    logic w_dec_lvl, w_dec_nxt, w_dec_rise;
    logic w_inc_ev, w_dec_ev;
    logic w_step;

    logic [DUTY_W-1:0] r_duty_reg;
    logic [DUTY_W-1:0] r_duty;
    logic              r_duty_upd;
    bcd3_t             r_bcd;
    logic [DUTY_W-1:0] w_duty_reg_nxt;
    logic [DUTY_W-1:0] w_duty_nxt;

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_en_deb (
        .clk(clk), .rst(rst), .raw(en_sw),
        .level(w_en_lvl), .level_nxt(w_en_nxt), .rise(w_en_rise)
    );

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc_deb (
        .clk(clk), .rst(rst), .raw(inc_sw),
        .level(w_inc_lvl), .level_nxt(w_inc_nxt), .rise(w_inc_rise)
    );

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dec_deb (
        .clk(clk), .rst(rst), .raw(dec_sw),
        .level(w_dec_lvl), .level_nxt(w_dec_nxt), .rise(w_dec_rise)
    );

`ifdef PWM_AUTO_REPEAT_EN
    localparam int                 c_rep_w    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [c_rep_w-1:0] c_rep_last = c_rep_w'(REPEAT_CYCLES - 1);

    logic [c_rep_w-1:0] r_rep_cnt;
    logic               w_hold_inc;
    logic               w_hold_dec;
    logic               w_rep_hit;

    // Only a lone held switch repeats; holding both counts as neither.
    assign w_hold_inc = w_inc_lvl & ~w_dec_lvl;
    assign w_hold_dec = w_dec_lvl & ~w_inc_lvl;
    assign w_rep_hit  = (w_hold_inc | w_hold_dec) & ~w_inc_rise & ~w_dec_rise
                        & (r_rep_cnt == c_rep_last);

    // Restarted by every event so repeats are spaced from the previous step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_cnt <= '0;
        end else if (!(w_hold_inc | w_hold_dec) || w_inc_rise || w_dec_rise || w_rep_hit) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + c_rep_w'(1);
        end
    end

    assign w_inc_ev = w_inc_rise | (w_rep_hit & w_hold_inc);
    assign w_dec_ev = w_dec_rise | (w_rep_hit & w_hold_dec);
`else
    logic w_unused_rep;

    assign w_inc_ev     = w_inc_rise;
    assign w_dec_ev     = w_dec_rise;
    assign w_unused_rep = (REPEAT_CYCLES != 0);
`endif

    logic w_unused_deb;
    assign w_unused_deb = ^{w_en_rise, w_inc_nxt, w_dec_nxt, w_inc_lvl, w_dec_lvl};

    // Simultaneous inc and dec cancel; nothing steps while disabled.
    assign w_step         = w_en_lvl & (w_inc_ev ^ w_dec_ev);
    assign w_duty_reg_nxt = w_step ? sat_step(r_duty_reg, w_inc_ev, c_step, c_max) : r_duty_reg;

    // Built from next-state values so duty moves on the same edge as
    // pwm_en and the duty register.
    assign w_duty_nxt = w_en_nxt ? w_duty_reg_nxt : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty_reg <= c_reset_duty;
            r_duty     <= '0;
            r_duty_upd <= 1'b0;
            r_bcd      <= '0;
        end else begin
            r_duty_reg <= w_duty_reg_nxt;
            r_duty     <= w_duty_nxt;
            r_duty_upd <= (w_duty_nxt != r_duty);
            r_bcd      <= to_bcd(r_duty);
        end
    end

    assign pwm_en   = w_en_lvl;
    assign duty     = r_duty;
    assign duty_upd = r_duty_upd;
    assign bcd_hund = r_bcd.hund;
    assign bcd_tens = r_bcd.tens;
    assign bcd_ones = r_bcd.ones;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module  : tb_pwm_duty_ctrl                                               |
// | Purpose : Self-checking bench for pwm_duty_ctrl (DEB_CYCLES=4). Table    |
// |           vectors, timing sequences and random switch activity checked   |
// |           against a sample-window reference model.                       |
// | Macro   : PWM_AUTO_REPEAT_EN enables the auto-repeat sequence and model. |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_pwm_duty_ctrl;

    localparam int DEB  = 4;
    localparam int STPV = 10;
    localparam int MAXD = 100;
    localparam int RSTD = 50;
    localparam int REP  = 20;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       en_sw  = 1'b0;
    logic       inc_sw = 1'b0;
    logic       dec_sw = 1'b0;
    logic       pwm_en;
    logic [6:0] duty;
    logic       duty_upd;
    logic [3:0] bcd_hund, bcd_tens, bcd_ones;

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt  = 0;
    bit chk_on   = 1'b0;

    pwm_duty_ctrl #(
        .DEB_CYCLES(DEB), .STEP(STPV), .MAX_DUTY(MAXD),
        .RESET_DUTY(RSTD), .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk), .rst(rst), .en_sw(en_sw), .inc_sw(inc_sw), .dec_sw(dec_sw),
        .pwm_en(pwm_en), .duty(duty), .duty_upd(duty_upd),
        .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bcd_of(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int bcd_out();
        return int'({bcd_hund, bcd_tens, bcd_ones});
    endfunction

    // Debounced level changes once the DEB samples that have cleared the
    // two-stage synchronizer all disagree with it.
    function automatic bit deb_next(input bit lvl, input bit [DEB+1:0] h);
        bit [DEB-1:0] w;
        w = h[DEB+1:2];
        if (!lvl && (&w)) return 1'b1;
        if (lvl && (w == '0)) return 1'b0;
        return lvl;
    endfunction

    // ---------------- reference model ----------------
    bit [DEB+1:0] h_en, h_inc, h_dec;
    bit l_en, l_inc, l_dec, rs_inc, rs_dec;
    bit m_en, m_upd;
    int m_reg, m_duty, m_bcd_v;
`ifdef PWM_AUTO_REPEAT_EN
    int since;
`endif

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            h_en = '0; h_inc = '0; h_dec = '0;
            l_en = 0; l_inc = 0; l_dec = 0; rs_inc = 0; rs_dec = 0;
            m_reg = RSTD; m_en = 0; m_duty = 0; m_upd = 0; m_bcd_v = 0;
`ifdef PWM_AUTO_REPEAT_EN
            since = 1;
`endif
        end else begin
            bit ev_inc, ev_dec, n_en, n_inc, n_dec;
            int nd;
            ev_inc = rs_inc;
            ev_dec = rs_dec;
`ifdef PWM_AUTO_REPEAT_EN
            begin
                bit hi, hd, rep;
                hi  = l_inc && !l_dec;
                hd  = l_dec && !l_inc;
                rep = (hi || hd) && !rs_inc && !rs_dec && (since == REP);
                if (rep) begin
                    ev_inc = ev_inc | hi;
                    ev_dec = ev_dec | hd;
                end
                if (!(hi || hd) || rs_inc || rs_dec || rep) since = 1;
                else since++;
            end
`endif
            if (l_en && (ev_inc != ev_dec)) begin
                if (ev_inc) m_reg = (m_reg + STPV > MAXD) ? MAXD : m_reg + STPV;
                else        m_reg = (m_reg < STPV) ? 0 : m_reg - STPV;
            end
            h_en  = {h_en[DEB:0],  en_sw};
            h_inc = {h_inc[DEB:0], inc_sw};
            h_dec = {h_dec[DEB:0], dec_sw};
            n_en  = deb_next(l_en,  h_en);
            n_inc = deb_next(l_inc, h_inc);
            n_dec = deb_next(l_dec, h_dec);
            rs_inc = n_inc && !l_inc;
            rs_dec = n_dec && !l_dec;
            l_en = n_en; l_inc = n_inc; l_dec = n_dec;
            nd      = n_en ? m_reg : 0;
            m_upd   = (nd != m_duty);
            m_bcd_v = m_duty;
            m_duty  = nd;
            m_en    = n_en;
        end
    end

    // Continuous comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("model_pwm_en",   int'(pwm_en),   int'(m_en));
            chk("model_duty",     int'(duty),     m_duty);
            chk("model_duty_upd", int'(duty_upd), int'(m_upd));
            chk("model_bcd",      bcd_out(),      bcd_of(m_bcd_v));
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (duty_upd === 1'b1) upd_cnt++;
    end

    // ---------------- vector table ----------------
    typedef struct {
        bit en, inc, dec;
        int cyc;
        bit exp_en;
        int exp_duty;
    } vec_t;
    vec_t vecs[$];

    function automatic void add_vec(input bit en, input bit inc, input bit dec,
                                    input int cyc, input bit xe, input int xd);
        vec_t v;
        v.en = en; v.inc = inc; v.dec = dec; v.cyc = cyc;
        v.exp_en = xe; v.exp_duty = xd;
        vecs.push_back(v);
    endfunction

    initial begin
        int u0, e, prev;
        int chg_k[$];
        int chg_v[$];

        // Table: entries assume duty=50 and enabled at the start.
        e = 50;
        add_vec(1, 0, 0, 10, 1, 50);
        add_vec(1, 1, 0, 2,  1, 50);
        add_vec(1, 0, 0, 10, 1, 50);
        for (int i = 0; i < 6; i++) begin
            e = (e + 10 > 100) ? 100 : e + 10;
            add_vec(1, 1, 0, 10, 1, e);
            add_vec(1, 0, 0, 10, 1, e);
        end
        for (int i = 0; i < 11; i++) begin
            e = (e < 10) ? 0 : e - 10;
            add_vec(1, 0, 1, 10, 1, e);
            add_vec(1, 0, 0, 10, 1, e);
        end
        for (int i = 0; i < 6; i++) begin
            e = e + 10;
            add_vec(1, 1, 0, 10, 1, e);
            add_vec(1, 0, 0, 10, 1, e);
        end
        add_vec(1, 1, 1, 10, 1, 60);
        add_vec(1, 0, 0, 10, 1, 60);
        add_vec(0, 0, 0, 10, 0, 0);
        add_vec(0, 1, 0, 10, 0, 0);
        add_vec(0, 0, 0, 10, 0, 0);
        add_vec(1, 0, 0, 10, 1, 60);

        // Reset state
        repeat (3) @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk_on = 1'b1;
        chk("rst_pwm_en", int'(pwm_en), 0);
        chk("rst_duty", int'(duty), 0);
        chk("rst_duty_upd", int'(duty_upd), 0);
        chk("rst_bcd", bcd_out(), 0);

        // Enable: duty shows the reset value with a single update pulse
        u0 = upd_cnt;
        en_sw = 1'b1;
        repeat (12) @(negedge clk);
        chk("en_pwm_en", int'(pwm_en), 1);
        chk("en_duty", int'(duty), 50);
        chk("en_bcd", bcd_out(), 'h050);
        chk("en_upd_pulses", upd_cnt - u0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            en_sw  = vecs[i].en;
            inc_sw = vecs[i].inc;
            dec_sw = vecs[i].dec;
            repeat (vecs[i].cyc) @(negedge clk);
            chk($sformatf("vec%0d_pwm_en", i), int'(pwm_en), int'(vecs[i].exp_en));
            chk($sformatf("vec%0d_duty", i), int'(duty), vecs[i].exp_duty);
            chk($sformatf("vec%0d_bcd", i), bcd_out(), bcd_of(vecs[i].exp_duty));
        end

        // Short pulse is discarded
        u0 = upd_cnt;
        inc_sw = 1'b1;
        repeat (2) @(negedge clk);
        inc_sw = 1'b0;
        repeat (10) @(negedge clk);
        chk("short_pulse_duty", int'(duty), 60);
        chk("short_pulse_upd", upd_cnt - u0, 0);

        // Exact latency: raw sampled at edge N, duty moves at N+6, BCD at N+7
        inc_sw = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) chk("lat_n5_duty", int'(duty), 60);
            if (k == 6) begin
                chk("lat_n6_duty", int'(duty), 70);
                chk("lat_n6_upd", int'(duty_upd), 1);
                chk("lat_n6_bcd", bcd_out(), 'h060);
            end
            if (k == 7) chk("lat_n7_bcd", bcd_out(), 'h070);
        end
        @(negedge clk);
        inc_sw = 1'b0;
        repeat (10) @(negedge clk);

        // Reset while the inc debounce count is 3
        inc_sw = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        inc_sw = 1'b0;
        #1;
        chk("midrst_pwm_en", int'(pwm_en), 0);
        chk("midrst_duty", int'(duty), 0);
        chk("midrst_bcd", bcd_out(), 0);
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        u0 = upd_cnt;
        repeat (20) @(negedge clk);
        chk("postrst_duty", int'(duty), 50);
        chk("postrst_pwm_en", int'(pwm_en), 1);
        chk("postrst_upd", upd_cnt - u0, 1);

`ifdef PWM_AUTO_REPEAT_EN
        // Hold inc for 70 cycles from 50
        prev = int'(duty);
        inc_sw = 1'b1;
        for (int k = 0; k < 110; k++) begin
            @(posedge clk);
            #1;
            if (int'(duty) != prev) begin
                chg_k.push_back(k);
                chg_v.push_back(int'(duty));
            end
            prev = int'(duty);
            if (k == 69) inc_sw = 1'b0;
        end
        chk("rep_changes", chg_k.size(), 4);
        if (chg_k.size() > 0) chk("rep_first_edge", chg_k[0], 6);
        for (int i = 0; i < chg_k.size() && i < 4; i++) begin
            chk($sformatf("rep_val%0d", i), chg_v[i], 60 + 10 * i);
            if (i > 0) chk($sformatf("rep_gap%0d", i), chg_k[i] - chg_k[i-1], REP);
        end
        @(negedge clk);
`else
        prev = 0;
        chg_k.delete();
        chg_v.delete();
`endif

        // Random switch activity against the model
        for (int s = 0; s < 200; s++) begin
            int hold;
            en_sw  = ($urandom % 5) != 0;
            inc_sw = ($urandom % 3) == 0;
            dec_sw = ($urandom % 3) == 0;
            hold   = (($urandom % 5) == 0) ? int'($urandom_range(20, 45))
                                           : int'($urandom_range(1, 8));
            repeat (hold) @(negedge clk);
        end
        en_sw = 1'b0; inc_sw = 1'b0; dec_sw = 1'b0;
        repeat (20) @(negedge clk);
        chk("final_duty_off", int'(duty), 0);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
